// File: rtl/mem_ctrler_pkg.sv
// Shared definitions for the cache-line memory controller: line geometry,
// FSM state encoding and the memory-mapped IO region check.
package mem_ctrler_pkg;

  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_LINE_WIDTH = 4;

  typedef logic [8*DEF_LINE_BYTES-1:0] cache_line_t;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_state_t;

  // Addresses with bits [17:16] == 2'b11 map to the UART and can back-pressure writes.
  function automatic logic is_io_region(input logic [1:0] addr_hi);
    return addr_hi == 2'b11;
  endfunction

endpackage

// File: rtl/mem_line_shifter.sv
// Byte-indexed cache-line buffer: whole-line load, one byte written at
// wr_ptr per enabled cycle, one byte read out at rd_ptr.
module mem_line_shifter #(
  parameter int LINE_BYTES = 16,
  parameter int LINE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [8*LINE_BYTES-1:0] load_line,
  input  logic                    wr_en,
  input  logic [LINE_WIDTH-1:0]   wr_ptr,
  input  logic [7:0]              wr_byte,
  input  logic [LINE_WIDTH-1:0]   rd_ptr,
  output logic [8*LINE_BYTES-1:0] line_merged,
  output logic [7:0]              rd_byte
);

  logic [8*LINE_BYTES-1:0] line_q;

  // line_merged already contains the byte being captured this cycle, so the
  // owner can publish the complete line on the same edge as the last capture.
  always_comb begin
    line_merged = line_q;
    line_merged[{wr_ptr, 3'b000} +: 8] = wr_byte;
  end

  assign rd_byte = line_q[{rd_ptr, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (wr_en) begin
      line_q <= line_merged;
    end
  end

endmodule

// File: rtl/mem_ctrler.sv
// Cache-line responder for the LSB and instruction fetcher: serialises each
// whole-line read or write-back onto the single byte-wide RAM port.
//
// state     | meaning
// MEM_IDLE  | waiting for a request; LSB has priority, no grant in a ready or flush cycle
// MEM_READ  | issue byte reads, capture mem_din one cycle later, pulse ready on last byte
// MEM_WRITE | write one byte per cycle, stall on full UART buffer in the IO region
module mem_ctrler
  import mem_ctrler_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    valid_from_ifetch,
  input  logic [31:0]             addr_from_ifetch,
  output logic                    ready_to_ifetch,
  output logic [8*LINE_BYTES-1:0] line_to_ifetch,
  input  logic                    valid_from_lsb,
  input  logic                    rw_flag_from_lsb,
  input  logic [31:0]             addr_from_lsb,
  input  logic [8*LINE_BYTES-1:0] line_from_lsb,
  output logic                    ready_to_lsb,
  output logic [8*LINE_BYTES-1:0] line_to_lsb,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int          PW        = LINE_WIDTH + 1;
  localparam logic [PW-1:0] PTR_END  = PW'(LINE_BYTES);
  localparam logic [PW-1:0] PTR_LAST = PW'(LINE_BYTES - 1);
  localparam logic [31:0] LINE_MASK = 32'(LINE_BYTES - 1);

  mem_state_t    state, state_n;
  logic          gnt_lsb;
  logic [31:0]   base;
  logic [PW-1:0] issue_ptr;
  logic [PW-1:0] cap_ptr;
  logic          pend;

  logic          grant_lsb, grant_if, grant;
  logic          issue, capture, cap_last;
  logic          wr_step, wr_last;
  logic [31:0]   grant_addr;
  logic [8*LINE_BYTES-1:0] line_merged;
  logic [7:0]    rd_byte;

  assign grant      = grant_lsb | grant_if;
  assign grant_addr = grant_lsb ? addr_from_lsb : addr_from_ifetch;

  always_comb begin
    state_n   = state;
    grant_lsb = 1'b0;
    grant_if  = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    cap_last  = 1'b0;
    wr_step   = 1'b0;
    wr_last   = 1'b0;
    case (state)
      MEM_IDLE: begin
        // The cycle carrying a ready pulse still sees the old request held valid.
        if (!flush && !ready_to_ifetch && !ready_to_lsb) begin
          if (valid_from_lsb) begin
            grant_lsb = 1'b1;
            state_n   = rw_flag_from_lsb ? MEM_WRITE : MEM_READ;
          end else if (valid_from_ifetch) begin
            grant_if = 1'b1;
            state_n  = MEM_READ;
          end
        end
      end
      MEM_READ: begin
        issue    = issue_ptr < PTR_END;
        capture  = pend;
        cap_last = pend && (cap_ptr == PTR_LAST);
        if (flush || cap_last) state_n = MEM_IDLE;
      end
      MEM_WRITE: begin
        wr_step = !(io_buffer_full && is_io_region(base[17:16]));
        wr_last = wr_step && (issue_ptr == PTR_LAST);
        if (wr_last) state_n = MEM_IDLE;
      end
      default: state_n = MEM_IDLE;
    endcase
  end

  // While frozen, re-address the pending byte so mem_din is valid for it on resume.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    if (state == MEM_READ) begin
      if (!rdy)       mem_a = base + 32'(cap_ptr);
      else if (issue) mem_a = base + 32'(issue_ptr);
    end else if (state == MEM_WRITE) begin
      mem_a    = base + 32'(issue_ptr);
      mem_dout = rd_byte;
    end
  end

  assign mem_wr = rdy & wr_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= MEM_IDLE;
      gnt_lsb         <= 1'b0;
      base            <= '0;
      issue_ptr       <= '0;
      cap_ptr         <= '0;
      pend            <= 1'b0;
      ready_to_ifetch <= 1'b0;
      ready_to_lsb    <= 1'b0;
      line_to_ifetch  <= '0;
      line_to_lsb     <= '0;
    end else if (rdy) begin
      state           <= state_n;
      ready_to_ifetch <= 1'b0;
      ready_to_lsb    <= 1'b0;
      if (grant) begin
        gnt_lsb   <= grant_lsb;
        base      <= grant_addr & ~LINE_MASK;
        issue_ptr <= '0;
        cap_ptr   <= '0;
        pend      <= 1'b0;
      end
      if (state == MEM_READ) begin
        if (flush) begin
          pend <= 1'b0;
        end else begin
          pend <= issue;
          if (issue)   issue_ptr <= issue_ptr + PW'(1);
          if (capture) cap_ptr   <= cap_ptr + PW'(1);
          if (cap_last) begin
            if (gnt_lsb) begin
              ready_to_lsb <= 1'b1;
              line_to_lsb  <= line_merged;
            end else begin
              ready_to_ifetch <= 1'b1;
              line_to_ifetch  <= line_merged;
            end
          end
        end
      end
      if (wr_step) begin
        issue_ptr <= issue_ptr + PW'(1);
        if (wr_last) ready_to_lsb <= 1'b1;
      end
    end
  end

  mem_line_shifter #(
    .LINE_BYTES(LINE_BYTES),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_line (
    .clk        (clk),
    .rst        (rst),
    .load       (rdy && grant_lsb && rw_flag_from_lsb),
    .load_line  (line_from_lsb),
    .wr_en      (rdy && capture && !flush),
    .wr_ptr     (cap_ptr[LINE_WIDTH-1:0]),
    .wr_byte    (mem_din),
    .rd_ptr     (issue_ptr[LINE_WIDTH-1:0]),
    .line_merged(line_merged),
    .rd_byte    (rd_byte)
  );

endmodule
